// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: memory-op encoding, access size, FSM state
// and small op-classification helpers.
package mem_stage_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned STRB_W = 4;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [3:0] {
        MOP_NONE = 4'd0,
        MOP_LB   = 4'd1,
        MOP_LBU  = 4'd2,
        MOP_LH   = 4'd3,
        MOP_LHU  = 4'd4,
        MOP_LW   = 4'd5,
        MOP_SB   = 4'd6,
        MOP_SH   = 4'd7,
        MOP_SW   = 4'd8
    } memop_t;

    typedef enum logic [1:0] {
        MSIZE_BYTE = 2'd0,
        MSIZE_HALF = 2'd1,
        MSIZE_WORD = 2'd2
    } msize_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic mem_is_load(input memop_t op);
        return (op == MOP_LB) || (op == MOP_LBU) || (op == MOP_LH) ||
               (op == MOP_LHU) || (op == MOP_LW);
    endfunction

    function automatic logic mem_is_store(input memop_t op);
        return (op == MOP_SB) || (op == MOP_SH) || (op == MOP_SW);
    endfunction

    function automatic msize_t mem_size(input memop_t op);
        case (op)
            MOP_LH, MOP_LHU, MOP_SH: return MSIZE_HALF;
            MOP_LW, MOP_SW:          return MSIZE_WORD;
            default:                 return MSIZE_BYTE;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store strobe/data placement and load extract/extend,
// driven by the op and the low two address bits.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  memop_t              op,
    input  logic [1:0]          addr_lo,
    input  logic [WORD_W-1:0]   wdata,
    input  logic [WORD_W-1:0]   rdata,
    output logic [STRB_W-1:0]   strobe_c,
    output logic [WORD_W-1:0]   sdata_c,
    output logic [WORD_W-1:0]   ldata_c
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        strobe_c = '0;
        sdata_c  = '0;
        ldata_c  = '0;
        rbyte    = 8'(rdata >> {addr_lo, 3'b000});
        rhalf    = 16'(rdata >> {addr_lo[1], 4'b0000});
        case (op)
            MOP_SB: begin
                strobe_c = 4'b0001 << addr_lo;
                sdata_c  = {4{wdata[7:0]}};
            end
            MOP_SH: begin
                strobe_c = 4'b0011 << {addr_lo[1], 1'b0};
                sdata_c  = {2{wdata[15:0]}};
            end
            MOP_SW: begin
                strobe_c = 4'hF;
                sdata_c  = wdata;
            end
            MOP_LB:  ldata_c = {{24{rbyte[7]}}, rbyte};
            MOP_LBU: ldata_c = {24'h0, rbyte};
            MOP_LH:  ldata_c = {{16{rhalf[15]}}, rhalf};
            MOP_LHU: ldata_c = {16'h0, rhalf};
            MOP_LW:  ldata_c = rdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: turns EX results into split-phase bus accesses (or passes them
// through) and hands a registered result to writeback over valid/ready.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   in_aluout,
    input  memop_t              in_op,
    input  logic [WORD_W-1:0]   in_wdata,
    input  logic [REG_W-1:0]    in_dst,
    input  logic                in_regwrite,
    output logic                dreq_valid,
    output logic [WORD_W-1:0]   dreq_addr,
    output logic [1:0]          dreq_size,
    output logic [STRB_W-1:0]   dreq_strobe,
    output logic [WORD_W-1:0]   dreq_data,
    input  logic                dresp_addr_ok,
    input  logic                dresp_data_ok,
    input  logic [WORD_W-1:0]   dresp_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORD_W-1:0]   out_result,
    output logic [REG_W-1:0]    out_dst,
    output logic                out_regwrite,
    output logic                out_exc
);

    state_t              state_q, state_d;
    memop_t              op_q, op_d;
    logic [REG_W-1:0]    dst_q, dst_d;
    logic                regwrite_q, regwrite_d;
    logic                dreq_valid_q, dreq_valid_d;
    logic [WORD_W-1:0]   dreq_addr_q, dreq_addr_d;
    msize_t              dreq_size_q, dreq_size_d;
    logic [STRB_W-1:0]   dreq_strobe_q, dreq_strobe_d;
    logic [WORD_W-1:0]   dreq_data_q, dreq_data_d;
    logic                out_valid_q, out_valid_d;
    logic [WORD_W-1:0]   out_result_q, out_result_d;
    logic [REG_W-1:0]    out_dst_q, out_dst_d;
    logic                out_regwrite_q, out_regwrite_d;
    logic                out_exc_q, out_exc_d;

    logic                xfer_c, busy_c, capture_c, misalign_c;
    msize_t              size_in_c;
    state_t              accept_state_c;
    memop_t              lane_op_c;
    logic [1:0]          lane_addr_c;
    logic [STRB_W-1:0]   strobe_c;
    logic [WORD_W-1:0]   sdata_c, ldata_c;

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign xfer_c    = in_valid && in_ready;
    assign busy_c    = (state_q == ST_REQ) || (state_q == ST_WAIT);
    // data_ok without addr_ok in REQ is a protocol violation and is ignored
    assign capture_c = ((state_q == ST_REQ) && dresp_addr_ok && dresp_data_ok) ||
                       ((state_q == ST_WAIT) && dresp_data_ok);

    assign size_in_c  = mem_size(in_op);
    assign misalign_c = ALIGN_CHECK && (in_op != MOP_NONE) &&
                        (((size_in_c == MSIZE_HALF) && in_aluout[0]) ||
                         ((size_in_c == MSIZE_WORD) && (in_aluout[1:0] != 2'b00)));
    assign accept_state_c = ((in_op == MOP_NONE) || misalign_c) ? ST_DONE : ST_REQ;

    // Store placement uses the incoming op; load extraction uses the latched one.
    assign lane_op_c   = busy_c ? op_q : in_op;
    assign lane_addr_c = busy_c ? dreq_addr_q[1:0] : in_aluout[1:0];

    mem_lane_align u_lane (
        .op       (lane_op_c),
        .addr_lo  (lane_addr_c),
        .wdata    (in_wdata),
        .rdata    (dresp_data),
        .strobe_c (strobe_c),
        .sdata_c  (sdata_c),
        .ldata_c  (ldata_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            op_q           <= MOP_NONE;
            dst_q          <= '0;
            regwrite_q     <= 1'b0;
            dreq_valid_q   <= 1'b0;
            dreq_addr_q    <= '0;
            dreq_size_q    <= MSIZE_BYTE;
            dreq_strobe_q  <= '0;
            dreq_data_q    <= '0;
            out_valid_q    <= 1'b0;
            out_result_q   <= '0;
            out_dst_q      <= '0;
            out_regwrite_q <= 1'b0;
            out_exc_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            dst_q          <= dst_d;
            regwrite_q     <= regwrite_d;
            dreq_valid_q   <= dreq_valid_d;
            dreq_addr_q    <= dreq_addr_d;
            dreq_size_q    <= dreq_size_d;
            dreq_strobe_q  <= dreq_strobe_d;
            dreq_data_q    <= dreq_data_d;
            out_valid_q    <= out_valid_d;
            out_result_q   <= out_result_d;
            out_dst_q      <= out_dst_d;
            out_regwrite_q <= out_regwrite_d;
            out_exc_q      <= out_exc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (xfer_c) state_d = accept_state_c;
            ST_REQ:  if (dresp_addr_ok) state_d = dresp_data_ok ? ST_DONE : ST_WAIT;
            ST_WAIT: if (dresp_data_ok) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = xfer_c ? accept_state_c : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_d           = op_q;
        dst_d          = dst_q;
        regwrite_d     = regwrite_q;
        dreq_addr_d    = dreq_addr_q;
        dreq_size_d    = dreq_size_q;
        dreq_strobe_d  = dreq_strobe_q;
        dreq_data_d    = dreq_data_q;
        out_result_d   = out_result_q;
        out_dst_d      = out_dst_q;
        out_regwrite_d = out_regwrite_q;
        out_exc_d      = out_exc_q;
        dreq_valid_d   = (state_d == ST_REQ);
        out_valid_d    = (state_d == ST_DONE);

        if (xfer_c) begin
            if (in_op == MOP_NONE) begin
                out_result_d   = in_aluout;
                out_dst_d      = in_dst;
                out_regwrite_d = in_regwrite;
                out_exc_d      = 1'b0;
            end else if (misalign_c) begin
                out_result_d   = in_aluout;
                out_dst_d      = in_dst;
                out_regwrite_d = 1'b0;
                out_exc_d      = 1'b1;
            end else begin
                op_d          = in_op;
                dst_d         = in_dst;
                regwrite_d    = in_regwrite && !mem_is_store(in_op);
                dreq_addr_d   = in_aluout;
                dreq_size_d   = size_in_c;
                dreq_strobe_d = strobe_c;
                dreq_data_d   = sdata_c;
            end
        end else if (capture_c) begin
            out_result_d   = mem_is_load(op_q) ? ldata_c : '0;
            out_dst_d      = dst_q;
            out_regwrite_d = regwrite_q;
            out_exc_d      = 1'b0;
        end
    end

    assign dreq_valid   = dreq_valid_q;
    assign dreq_addr    = dreq_addr_q;
    assign dreq_size    = dreq_size_q;
    assign dreq_strobe  = dreq_strobe_q;
    assign dreq_data    = dreq_data_q;
    assign out_valid    = out_valid_q;
    assign out_result   = out_result_q;
    assign out_dst      = out_dst_q;
    assign out_regwrite = out_regwrite_q;
    assign out_exc      = out_exc_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected WB results into a
// queue, an independent monitor pops and compares on each WB handshake.
module tb_mem_stage;
    import mem_stage_pkg::*;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  dst;
        logic        rw;
        logic        exc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_aluout;
    memop_t      in_op;
    logic [31:0] in_wdata;
    logic [4:0]  in_dst;
    logic        in_regwrite;
    logic        dreq_valid;
    logic [31:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [3:0]  dreq_strobe;
    logic [31:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [31:0] dresp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_dst;
    logic        out_regwrite;
    logic        out_exc;

    logic        n_in_ready, n_dreq_valid, n_out_valid, n_out_regwrite, n_out_exc;
    logic [31:0] n_dreq_addr, n_dreq_data, n_out_result;
    logic [1:0]  n_dreq_size;
    logic [3:0]  n_dreq_strobe;
    logic [4:0]  n_out_dst;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_stage #(.ALIGN_CHECK(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_aluout(in_aluout),
        .in_op(in_op), .in_wdata(in_wdata), .in_dst(in_dst), .in_regwrite(in_regwrite),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_dst(out_dst), .out_regwrite(out_regwrite), .out_exc(out_exc)
    );

    mem_stage #(.ALIGN_CHECK(1'b0)) u_dut_noalign (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_aluout(in_aluout),
        .in_op(in_op), .in_wdata(in_wdata), .in_dst(in_dst), .in_regwrite(in_regwrite),
        .dreq_valid(n_dreq_valid), .dreq_addr(n_dreq_addr), .dreq_size(n_dreq_size),
        .dreq_strobe(n_dreq_strobe), .dreq_data(n_dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_result(n_out_result),
        .out_dst(n_out_dst), .out_regwrite(n_out_regwrite), .out_exc(n_out_exc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: a WB handshake completes at the next posedge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", out_result, 32'hxxxx_xxxx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_result",   out_result,          e.result);
                chk("wb_dst",      32'(out_dst),        32'(e.dst));
                chk("wb_regwrite", 32'(out_regwrite),   32'(e.rw));
                chk("wb_exc",      32'(out_exc),        32'(e.exc));
            end
        end
    end

    function automatic exp_t mk(input logic [31:0] r, input logic [4:0] d,
                                input logic rw, input logic exc);
        exp_t e;
        e.result = r; e.dst = d; e.rw = rw; e.exc = exc;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the transfer edge.
    task automatic send(input memop_t op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] dst, input logic rw);
        int budget;
        in_valid = 1'b1; in_op = op; in_aluout = addr; in_wdata = wd;
        in_dst = dst; in_regwrite = rw;
        budget = 50;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            budget--;
            if (budget == 0) begin
                chk("send_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Entered in REQ at posedge+1; returns at posedge+1 after the data phase.
    task automatic bus_resp(input int addr_wait, input int data_wait, input logic [31:0] rd);
        logic [31:0] a, d;
        logic [1:0]  s;
        logic [3:0]  st;
        a = dreq_addr; s = dreq_size; st = dreq_strobe; d = dreq_data;
        repeat (addr_wait) begin
            @(posedge clk); #1;
            chk("req_valid_held",  32'(dreq_valid),  32'd1);
            chk("req_addr_held",   dreq_addr,        a);
            chk("req_size_held",   32'(dreq_size),   32'(s));
            chk("req_strobe_held", 32'(dreq_strobe), 32'(st));
            chk("req_data_held",   dreq_data,        d);
            chk("req_in_ready",    32'(in_ready),    32'd0);
        end
        dresp_addr_ok = 1'b1; dresp_data_ok = (data_wait == 0); dresp_data = rd;
        @(posedge clk); #1;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
        if (data_wait > 0) begin
            repeat (data_wait - 1) begin
                chk("wait_dreq_valid", 32'(dreq_valid), 32'd0);
                chk("wait_in_ready",   32'(in_ready),   32'd0);
                @(posedge clk); #1;
            end
            chk("wait_dreq_valid", 32'(dreq_valid), 32'd0);
            dresp_data_ok = 1'b1; dresp_data = rd;
            @(posedge clk); #1;
            dresp_data_ok = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got 0 expected 1)");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_aluout = '0; in_op = MOP_NONE; in_wdata = '0;
        in_dst = '0; in_regwrite = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
        dresp_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid",    32'(out_valid),    32'd0);
        chk("rst_dreq_valid",   32'(dreq_valid),   32'd0);
        chk("rst_out_regwrite", 32'(out_regwrite), 32'd0);
        chk("rst_out_exc",      32'(out_exc),      32'd0);
        chk("rst_out_result",   out_result,        32'd0);
        chk("rst_dreq_addr",    dreq_addr,         32'd0);
        chk("rst_dreq_strobe",  32'(dreq_strobe),  32'd0);
        chk("rst_in_ready",     32'(in_ready),     32'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        // Pass-through, three back-to-back ops
        in_valid = 1'b1; in_op = MOP_NONE; in_regwrite = 1'b1;
        in_aluout = 32'h1234_5678; in_dst = 5'd5; sb.push_back(mk(32'h1234_5678, 5'd5, 1'b1, 1'b0));
        @(posedge clk); #1;
        chk("pt_latency_valid", 32'(out_valid), 32'd1);
        in_aluout = 32'h0000_00A5; in_dst = 5'd6; sb.push_back(mk(32'h0000_00A5, 5'd6, 1'b1, 1'b0));
        @(posedge clk); #1;
        in_aluout = 32'hFFFF_0001; in_dst = 5'd7; in_regwrite = 1'b0;
        sb.push_back(mk(32'hFFFF_0001, 5'd7, 1'b0, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk); #2;
        chk("pt_throughput_drained", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;

        // LB / LBU sign vs zero extension, single-cycle bus response
        send(MOP_LB, 32'h8000_0003, 32'h0, 5'd9, 1'b1);
        chk("lb_dreq_valid",  32'(dreq_valid),  32'd1);
        chk("lb_dreq_size",   32'(dreq_size),   32'd0);
        chk("lb_dreq_strobe", 32'(dreq_strobe), 32'd0);
        chk("lb_dreq_addr",   dreq_addr,        32'h8000_0003);
        sb.push_back(mk(32'hFFFF_FF80, 5'd9, 1'b1, 1'b0));
        bus_resp(0, 0, 32'h80FF_FFFF);
        send(MOP_LBU, 32'h8000_0003, 32'h0, 5'd10, 1'b1);
        sb.push_back(mk(32'h0000_0080, 5'd10, 1'b1, 1'b0));
        bus_resp(0, 0, 32'h80FF_FFFF);
        send(MOP_LH, 32'h0000_0002, 32'h0, 5'd11, 1'b1);
        chk("lh_dreq_size", 32'(dreq_size), 32'd1);
        sb.push_back(mk(32'hFFFF_8001, 5'd11, 1'b1, 1'b0));
        bus_resp(0, 0, 32'h8001_7FFF);

        // SH lane placement and SB at byte 1
        send(MOP_SH, 32'h0000_0102, 32'hAAAA_BEEF, 5'd12, 1'b1);
        chk("sh_dreq_strobe", 32'(dreq_strobe), 32'h0000_000C);
        chk("sh_dreq_data",   dreq_data,        32'hBEEF_BEEF);
        chk("sh_dreq_size",   32'(dreq_size),   32'd1);
        sb.push_back(mk(32'h0, 5'd12, 1'b0, 1'b0));
        bus_resp(1, 0, 32'h1111_1111);
        send(MOP_SB, 32'h0000_0201, 32'h1234_5677, 5'd13, 1'b1);
        chk("sb_dreq_strobe", 32'(dreq_strobe), 32'h0000_0002);
        chk("sb_dreq_data",   dreq_data,        32'h7777_7777);
        sb.push_back(mk(32'h0, 5'd13, 1'b0, 1'b0));
        bus_resp(0, 0, 32'h0);

        // Split phases with stalls
        send(MOP_LW, 32'h0000_0100, 32'h0, 5'd14, 1'b1);
        chk("lw_dreq_size",   32'(dreq_size),   32'd2);
        chk("lw_dreq_strobe", 32'(dreq_strobe), 32'd0);
        sb.push_back(mk(32'hDEAD_BEEF, 5'd14, 1'b1, 1'b0));
        bus_resp(3, 2, 32'hDEAD_BEEF);

        // Misaligned word: exception, no bus request; without checking, a request
        send(MOP_LW, 32'h0000_0006, 32'h0, 5'd15, 1'b1);
        chk("mis_no_dreq",       32'(dreq_valid),   32'd0);
        chk("mis_noalign_dreq",  32'(n_dreq_valid), 32'd1);
        chk("mis_noalign_addr",  n_dreq_addr,       32'h0000_0006);
        sb.push_back(mk(32'h0000_0006, 5'd15, 1'b0, 1'b1));
        @(posedge clk); #1;

        // Backpressure in DONE
        out_ready = 1'b0;
        send(MOP_NONE, 32'h0000_CAFE, 32'h0, 5'd3, 1'b1);
        sb.push_back(mk(32'h0000_CAFE, 5'd3, 1'b1, 1'b0));
        in_valid = 1'b1; in_aluout = 32'h0BAD_0BAD;
        repeat (4) begin
            chk("bp_out_valid",  32'(out_valid), 32'd1);
            chk("bp_out_result", out_result,     32'h0000_CAFE);
            chk("bp_in_ready",   32'(in_ready),  32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_drained", 32'(sb.size()), 32'd0);

        // Reset while waiting for the data phase; a late data_ok must be ignored
        send(MOP_LW, 32'h0000_0200, 32'h0, 5'd8, 1'b1);
        dresp_addr_ok = 1'b1;
        @(posedge clk); #1;
        dresp_addr_ok = 1'b0;
        chk("mr_in_wait", 32'(dreq_valid), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mr_out_valid",  32'(out_valid),  32'd0);
        chk("mr_dreq_valid", 32'(dreq_valid), 32'd0);
        chk("mr_in_ready",   32'(in_ready),   32'd1);
        chk("mr_dreq_addr",  dreq_addr,       32'd0);
        dresp_data_ok = 1'b1; dresp_data = 32'h5555_AAAA;
        @(posedge clk); #1;
        dresp_data_ok = 1'b0;
        repeat (2) begin
            chk("mr_late_ignored", 32'(out_valid), 32'd0);
            chk("mr_result_zero",  out_result,     32'd0);
            @(posedge clk); #1;
        end

        chk("sb_empty_at_end", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
